// File: rtl/risc_constants.sv
// Shared ALU operation codes and result flag payload.
package risc_constants;

    localparam int unsigned FN_W = 6;

    typedef logic [FN_W-1:0] alu_fn_t;

    localparam alu_fn_t alu_ADD    = 6'h00;
    localparam alu_fn_t alu_SUB    = 6'h01;
    localparam alu_fn_t alu_AND    = 6'h02;
    localparam alu_fn_t alu_OR     = 6'h03;
    localparam alu_fn_t alu_XOR    = 6'h04;
    localparam alu_fn_t alu_XNOR   = 6'h05;
    localparam alu_fn_t alu_A      = 6'h06;
    localparam alu_fn_t alu_SHL    = 6'h07;
    localparam alu_fn_t alu_SHR    = 6'h08;
    localparam alu_fn_t alu_SRA    = 6'h09;
    localparam alu_fn_t alu_CMPEQ  = 6'h0A;
    localparam alu_fn_t alu_CMPLT  = 6'h0B;
    localparam alu_fn_t alu_CMPLE  = 6'h0C;
    localparam alu_fn_t alu_MUL    = 6'h0D;
    localparam alu_fn_t alu_DIV    = 6'h0E;
    localparam alu_fn_t alu_CMPLTU = 6'h10;
    localparam alu_fn_t alu_REM    = 6'h11;

    typedef struct packed {
        logic div_zero;
        logic illegal_fn;
    } alu_flags_t;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring unsigned divider: one quotient bit per cycle, done pulses after WIDTH iterations.
module alu_div_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Shift the next dividend bit into the partial remainder and keep it if the trial subtract is non-negative.
    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dsr_q};
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            dsr_d  = divisor;
            cnt_d  = CW'(WIDTH);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                rem_d  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                quo_d  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                cnt_d  = cnt_q - CW'(1);
                done_d = (cnt_q == CW'(1));
            end else begin
                busy_d = 1'b0;
            end
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops complete from IDLE, DIV/REM run on the iterative divider.
module alu_mc
    import risc_constants::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIV_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [FN_W-1:0]  fn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             div_zero,
    output logic             illegal_fn
);

    localparam int unsigned SHW    = $clog2(WIDTH);
    localparam bit          DIV_ON = (DIV_EN != 0);

    typedef enum logic [1:0] {IDLE, DIVIDE, HOLD} state_t;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    alu_flags_t       flags_q, flags_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             b_neg_q, b_neg_d;
    logic             b_zero_q, b_zero_d;
    logic             is_rem_q, is_rem_d;

    logic             accept;
    logic             is_div;
    logic             div_start;
    logic             div_done;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] quo_mag, rem_mag;
    logic [WIDTH-1:0] quo_s, rem_s;
    logic [WIDTH-1:0] div_res;
    logic [WIDTH-1:0] alu_res;
    logic             alu_legal;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_div   = DIV_ON && ((fn == alu_DIV) || (fn == alu_REM));
    assign shamt    = b[SHW-1:0];
    assign a_mag    = a[WIDTH-1] ? (WIDTH'(0) - a) : a;
    assign b_mag    = b[WIDTH-1] ? (WIDTH'(0) - b) : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            a_q         <= '0;
            b_neg_q     <= 1'b0;
            b_zero_q    <= 1'b0;
            is_rem_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            a_q         <= a_d;
            b_neg_q     <= b_neg_d;
            b_zero_q    <= b_zero_d;
            is_rem_q    <= is_rem_d;
        end
    end

    // Single-cycle datapath; anything not listed is illegal and yields zero.
    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        case (fn)
            alu_ADD:    alu_res = a + b;
            alu_SUB:    alu_res = a - b;
            alu_MUL:    alu_res = WIDTH'(a * b);
            alu_AND:    alu_res = a & b;
            alu_OR:     alu_res = a | b;
            alu_XOR:    alu_res = a ^ b;
            alu_XNOR:   alu_res = ~(a ^ b);
            alu_A:      alu_res = a;
            alu_SHL:    alu_res = a << shamt;
            alu_SHR:    alu_res = a >> shamt;
            alu_SRA:    alu_res = WIDTH'($signed(a) >>> shamt);
            alu_CMPEQ:  alu_res = WIDTH'(a == b);
            alu_CMPLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            alu_CMPLTU: alu_res = WIDTH'(a < b);
            alu_CMPLE:  alu_res = WIDTH'($signed(a) <= $signed(b));
            default:    alu_legal = 1'b0;
        endcase
    end

    // Restore signs on the magnitude result; divide-by-zero overrides the divider output.
    always_comb begin
        quo_s = (a_q[WIDTH-1] ^ b_neg_q) ? (WIDTH'(0) - quo_mag) : quo_mag;
        rem_s = a_q[WIDTH-1] ? (WIDTH'(0) - rem_mag) : rem_mag;
        if (b_zero_q) begin
            div_res = is_rem_q ? a_q : '1;
        end else begin
            div_res = is_rem_q ? rem_s : quo_s;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flags_d     = flags_q;
        a_d         = a_q;
        b_neg_d     = b_neg_q;
        b_zero_d    = b_zero_q;
        is_rem_d    = is_rem_q;
        div_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (is_div) begin
                        state_d   = DIVIDE;
                        div_start = 1'b1;
                        a_d       = a;
                        b_neg_d   = b[WIDTH-1];
                        b_zero_d  = (b == '0);
                        is_rem_d  = (fn == alu_REM);
                    end else begin
                        out_valid_d        = 1'b1;
                        result_d           = alu_res;
                        flags_d.div_zero   = 1'b0;
                        flags_d.illegal_fn = !alu_legal;
                    end
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    state_d            = HOLD;
                    out_valid_d        = 1'b1;
                    result_d           = div_res;
                    flags_d.div_zero   = b_zero_q;
                    flags_d.illegal_fn = 1'b0;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    generate
        if (DIV_ON) begin : g_div
            alu_div_iter #(.WIDTH(WIDTH)) u_div (
                .clk       (clk),
                .rst_n     (rst_n),
                .start     (div_start),
                .dividend  (a_mag),
                .divisor   (b_mag),
                .done      (div_done),
                .quotient  (quo_mag),
                .remainder (rem_mag)
            );
        end else begin : g_no_div
            assign div_done = 1'b0;
            assign quo_mag  = '0;
            assign rem_mag  = '0;
        end
    endgenerate

    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign div_zero   = flags_q.div_zero;
    assign illegal_fn = flags_q.illegal_fn;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: random and directed ops against an arithmetic reference model.
module tb_alu_mc;
    import risc_constants::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         dz;
        logic         ill;
        int           exp_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [5:0]    fn = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          div_zero;
    logic          illegal_fn;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   seen = 0;
    bit   rand_ready = 0;
    bit   ready_hold = 1;

    alu_mc #(.WIDTH(W), .DIV_EN(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .fn         (fn),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .div_zero   (div_zero),
        .illegal_fn (illegal_fn)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spec-level reference: plain arithmetic on signed/unsigned 64-bit values.
    function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t   e;
        longint sx = $signed(x);
        longint sy = $signed(y);
        longint ux = x;
        longint uy = y;
        logic [4:0] sh = y[4:0];
        e.res = '0; e.dz = 1'b0; e.ill = 1'b0; e.exp_cyc = 1;
        case (f)
            alu_ADD:    e.res = W'(ux + uy);
            alu_SUB:    e.res = W'(ux - uy);
            alu_MUL:    e.res = W'(ux * uy);
            alu_AND:    e.res = x & y;
            alu_OR:     e.res = x | y;
            alu_XOR:    e.res = x ^ y;
            alu_XNOR:   e.res = ~(x ^ y);
            alu_A:      e.res = x;
            alu_SHL:    e.res = x << sh;
            alu_SHR:    e.res = x >> sh;
            alu_SRA:    e.res = W'(sx >>> sh);
            alu_CMPEQ:  e.res = W'(ux == uy);
            alu_CMPLT:  e.res = W'(sx < sy);
            alu_CMPLTU: e.res = W'(ux < uy);
            alu_CMPLE:  e.res = W'(sx <= sy);
            alu_DIV, alu_REM: begin
                e.exp_cyc = W + 2;
                if (uy == 0) begin
                    e.dz  = 1'b1;
                    e.res = (f == alu_DIV) ? '1 : x;
                end else begin
                    e.res = (f == alu_DIV) ? W'(sx / sy) : W'(sx % sy);
                end
            end
            default:    e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Monitor: compare the presented result with the scoreboard head on every valid cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
            seen = 0;
        end else if (out_valid) begin
            if (sbq.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'(0));
            end else begin
                check("result", 64'(result), 64'(sbq[0].res));
                check("div_zero", 64'(div_zero), 64'(sbq[0].dz));
                check("illegal_fn", 64'(illegal_fn), 64'(sbq[0].ill));
                if (!seen) begin
                    check("latency", 64'(cyc), 64'(sbq[0].exp_cyc));
                    seen = 1;
                end
                if (out_ready) begin
                    void'(sbq.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        int   n = 0;
        fn = f; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
            return;
        end
        e = model(f, x, y);
        e.exp_cyc += cyc;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (sbq.size() != 0) check("drain_timeout", 64'(sbq.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] edge_vals [6];
        edge_vals = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF,
                      32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0002};
        if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 5)];
        if ($urandom_range(0, 1) == 0) return W'($urandom_range(0, 40)) - W'(20);
        return W'($urandom());
    endfunction

    initial begin
        logic [5:0] fn_list [17];
        fn_list = '{alu_ADD, alu_SUB, alu_AND, alu_OR, alu_XOR, alu_XNOR, alu_A, alu_SHL,
                    alu_SHR, alu_SRA, alu_CMPEQ, alu_CMPLT, alu_CMPLE, alu_MUL, alu_CMPLTU,
                    alu_DIV, alu_REM};

        // Reset state
        wait_cycles(3);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'(0));
        check("reset_result", 64'(result), 64'(0));
        check("reset_div_zero", 64'(div_zero), 64'(0));
        check("reset_illegal_fn", 64'(illegal_fn), 64'(0));
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        // Directed corner cases
        issue(alu_ADD, 32'h7FFF_FFFF, 32'h1);
        issue(alu_DIV, -32'sd7, 32'd2);
        issue(alu_REM, -32'sd7, 32'd2);
        issue(alu_DIV, 32'd5, 32'd0);
        issue(alu_REM, 32'd5, 32'd0);
        issue(alu_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(alu_REM, 32'h8000_0000, 32'hFFFF_FFFF);
        issue(alu_SRA, 32'h8000_0000, 32'h21);
        issue(alu_CMPLTU, 32'd1, 32'hFFFF_FFFF);
        issue(alu_CMPLT, 32'd1, 32'hFFFF_FFFF);
        issue(alu_CMPLE, 32'h8000_0000, 32'h8000_0000);
        issue(alu_SHL, 32'h0000_0003, 32'hFFFF_FFFF);
        issue(alu_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
        issue(6'h3F, 32'h1234, 32'h5678);
        drain();

        // Stall: result held, no new accept; then a back-to-back stream
        ready_hold = 0;
        wait_cycles(1);
        issue(alu_ADD, 32'd100, 32'd23);
        repeat (5) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'(0));
        end
        @(posedge clk);
        #1;
        ready_hold = 1;
        for (int i = 0; i < 8; i++) issue(alu_ADD, W'(i * 1000), W'(i + 1));
        drain();

        // Divide result held in HOLD while the consumer stalls
        ready_hold = 0;
        wait_cycles(1);
        issue(alu_DIV, 32'd1000, -32'sd7);
        wait_cycles(45);
        ready_hold = 1;
        drain();

        // Reset in the middle of a divide discards it
        issue(alu_ADD, 32'd5, 32'd6);
        drain();
        issue(alu_DIV, 32'd12345, 32'd17);
        wait_cycles(10);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 64'(out_valid), 64'(0));
        check("midreset_result", 64'(result), 64'(0));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("in_ready_after_midreset", 64'(in_ready), 64'(1));
        wait_cycles(60);
        issue(6'h3F, 32'hDEAD_BEEF, 32'h1);
        drain();

        // Random traffic with random consumer backpressure
        rand_ready = 1;
        for (int i = 0; i < 150; i++) begin
            logic [5:0] f;
            if ($urandom_range(0, 9) == 0) f = 6'($urandom());
            else f = fn_list[$urandom_range(0, 16)];
            issue(f, pick_operand(), pick_operand());
            if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 3));
        end
        drain();
        rand_ready = 0;
        wait_cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32; operand and result width in bits, legal values 8..64, power of two.
REQ-002 Parameter DIV_EN, default 1; 1 includes the iterative divider, 0 treats DIV/REM as illegal.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operation request valid.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 a  input  WIDTH  operand A, two's complement.
REQ-008 b  input  WIDTH  operand B, two's complement.
REQ-009 fn  input  6  operation code from the shared constants.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  operation result.
REQ-013 div_zero  output  1  result came from DIV/REM with b == 0; qualified by out_valid.
REQ-014 illegal_fn  output  1  result came from an unsupported fn; qualified by out_valid.

Function
REQ-015 Request accepted on a rising edge where in_valid && in_ready; a, b and fn are captured at that edge.
REQ-016 in_ready = (state == IDLE) && (!out_valid || out_ready); back-to-back single-cycle ops sustain one per clock.
REQ-017 States: IDLE, DIVIDE, HOLD. IDLE -> DIVIDE on accepting DIV/REM; DIVIDE -> HOLD after the final iteration; HOLD -> IDLE on out_valid && out_ready.
REQ-018 Single-cycle ops complete in IDLE: out_valid is asserted in the cycle after acceptance (latency 1).
REQ-019 Single-cycle ops: CMPEQ, CMPLT (signed), CMPLTU (unsigned, new), CMPLE (signed), ADD, SUB, MUL (low WIDTH bits), AND, OR, XOR, XNOR, A, SHL, SHR (logical), SRA.
REQ-020 Compare ops return 1 or 0 zero-extended to WIDTH; ADD/SUB/MUL wrap modulo 2^WIDTH with no overflow flag.
REQ-021 Shift amount is b[$clog2(WIDTH)-1:0]; upper bits of b are ignored.
REQ-022 DIV (signed quotient, truncating toward zero) and REM (new; remainder takes sign of a) use a restoring divider of one bit per cycle on magnitudes.
REQ-023 DIV/REM latency is exactly WIDTH+2 cycles from acceptance edge to first out_valid cycle, independent of operand values.
REQ-024 b == 0: DIV returns all ones, REM returns a, div_zero = 1; latency unchanged.
REQ-025 a == most-negative and b == -1: DIV returns most-negative, REM returns 0, div_zero = 0.
REQ-026 Undefined fn, or DIV/REM with DIV_EN = 0: result 0, illegal_fn = 1, latency 1.
REQ-027 While out_valid && !out_ready, result, div_zero and illegal_fn hold stable and in_ready = 0.
REQ-028 in_valid held during DIVIDE/HOLD is not accepted and leaves internal state unchanged.
REQ-029 out_valid deasserts in the cycle after the handshake unless a new single-cycle op is accepted on the same edge.

Reset
REQ-030 On rst_n low: state = IDLE, out_valid = 0, result = 0, div_zero = 0, illegal_fn = 0, divider registers cleared.
REQ-031 Reset during DIVIDE or HOLD discards the pending operation; no result is produced after reset release.
REQ-032 in_ready = 1 in the first cycle after rst_n deasserts.

Structure
REQ-033 All fn codes, including new alu_CMPLTU and alu_REM, are defined in the shared risc_constants package; existing code values are unchanged.
REQ-034 The state enumeration is local to alu_mc; it is not placed in the package.
REQ-035 The iterative divider is a sub-module alu_div_iter (start, operands, done, quotient, remainder), instantiated only when DIV_EN = 1.

Verification
REQ-036 ADD a=0x7FFFFFFF, b=1 -> one cycle later result=0x80000000, out_valid=1, flags 0.
REQ-037 DIV a=-7, b=2 (WIDTH=32) -> out_valid exactly 34 cycles after accept, result=-3; REM same operands -> result=-1.
REQ-038 DIV a=5, b=0 -> result=0xFFFFFFFF, div_zero=1; DIV a=0x80000000, b=-1 -> result=0x80000000, div_zero=0.
REQ-039 SRA a=0x80000000, b=0x21 -> result=0xC0000000 (amount 1); CMPLTU a=1, b=-1 -> 1; CMPLT same operands -> 0.
REQ-040 out_ready held low 5 cycles after ADD result -> result stable, in_ready=0; then stream 8 ADDs with out_ready=1 -> one result per cycle, in order.
REQ-041 rst_n pulsed low mid-DIV -> out_valid=0, result=0 immediately; no stale result after release; fn=0x3F -> illegal_fn=1, result=0.
